unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbitrates the multi-cycle core's separate instruction-fetch and data-access ports onto one shared single-port memory with a read/write-pulse plus ready handshake. Captures single-cycle request pulses from the core and issues them to memory one at a time, data before instruction. Returns read data and a one-cycle ready pulse to the requesting port. Sits between the multi-cycle core and the unified memory model or bus bridge, and keeps wrapping completion counters for performance monitoring.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_addr_i  in  ADDR_WIDTH  fetch address, sampled with instr_req_i
- instr_req_i  in  1  one-cycle fetch request pulse
- instr_rdata_o  out  DATA_WIDTH  fetched word, valid with instr_ready_o
- instr_ready_o  out  1  one-cycle fetch completion pulse
- data_addr_i  in  ADDR_WIDTH  load/store address
- data_wdata_i  in  DATA_WIDTH  store data
- data_wstrb_i  in  DATA_WIDTH/8  store byte strobes
- data_read_i  in  1  one-cycle load request pulse
- data_write_i  in  1  one-cycle store request pulse
- data_rdata_o  out  DATA_WIDTH  load data, valid with data_ready_o
- data_ready_o  out  1  one-cycle load/store completion pulse
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_wstrb_o  out  DATA_WIDTH/8  memory write strobes; 0 for reads
- mem_read_o  out  1  one-cycle memory read pulse
- mem_write_o  out  1  one-cycle memory write pulse
- mem_rdata_i  in  DATA_WIDTH  memory read data
- mem_ready_i  in  1  memory completion pulse
- err_o  out  1  sticky protocol error flag
- instr_cnt_o  out  32  completed fetches, wraps
- data_cnt_o  out  32  completed data accesses, wraps

## Operation
- Each requester has a pending slot: valid bit, address, and for data also wdata, wstrb and an is_write bit.
- A request pulse loads its slot at the clock edge. data_write_i and data_read_i together: write wins, err_o is set.
- A pulse arriving while its own slot is valid and not completing this cycle is dropped and sets err_o. If the slot completes in the same cycle, the new request is accepted (set wins over clear).
- err_o is cleared only by reset.
- FSM states:
  - IDLE: if any slot is valid, grant data when data is valid, else instruction. Assert mem_read_o or mem_write_o for this cycle, record the grant, go to WAIT. With no valid slot, stay in IDLE.
  - WAIT: on mem_ready_i, pulse the granted port's ready, clear its slot, increment its counter, go to IDLE. Otherwise hold.
- mem_addr_o, mem_wdata_o and mem_wstrb_o are driven from the granted slot in IDLE-issue and throughout WAIT, and held stable until mem_ready_i.
- In pure IDLE with no grant, mem_addr_o, mem_wdata_o and mem_wstrb_o are 0. mem_wstrb_o is 0 for reads.
- instr_rdata_o and data_rdata_o pass mem_rdata_i through combinationally, and are 0 when the matching ready is low.
- mem_ready_i outside WAIT is ignored.
- No preemption. A data request arriving during an instruction WAIT is served next.

## Timing
- Reset values: every output 0, FSM in IDLE, both slots invalid, counters 0, err_o 0.
- Reset asserted mid-transaction aborts it immediately. No ready pulse is produced; memory outputs drop to 0 asynchronously.
- Minimum latency: request pulse in cycle N, memory pulse in cycle N+1, mem_ready_i in N+2 at earliest, port ready in N+2, same cycle as mem_ready_i.
- Back-to-back: the next grant issues in the IDLE cycle immediately after completion. There is one idle-issue cycle between transactions.
- Simultaneous instruction and data pulses in cycle N: data issues at N+1, instruction issues the cycle after data completes.
- Counters are 32-bit and wrap 0xFFFFFFFF -> 0.

## Test plan
- Single fetch: instr_req_i with address 0x100, memory returns 0x00500093 after 3 cycles. Expect mem_read_o one cycle after the request, mem_addr_o = 0x100 held, instr_ready_o with rdata 0x00500093, instr_cnt_o = 1.
- Store: data_write_i with address 0x200, wdata 0xDEADBEEF, wstrb 0xF. Expect mem_write_o with those values, data_ready_o on mem_ready_i, data_cnt_o = 1, instr port quiet.
- Simultaneous fetch and load in the same cycle: expect the data read issued first and data_ready_o first. Then the fetch issues in the cycle after, and instr_ready_o follows.
- Duplicate fetch pulse while one is pending: expect the original address served, the duplicate dropped, err_o = 1 until rst_n.
- Reset mid-WAIT: assert rst_n low two cycles after mem_read_o. Expect all outputs 0 at once, and no ready pulse after release even if mem_ready_i arrives.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between the core's
// instruction-fetch and data ports. Requests are captured as one-cycle
// pulses into per-port pending slots and issued one at a time, data first.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    input  logic                    instr_req_i,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic                    instr_ready_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] data_wstrb_i,
    input  logic                    data_read_i,
    input  logic                    data_write_i,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_ready_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ready_i,
    output logic                    err_o,
    output logic [31:0]             instr_cnt_o,
    output logic [31:0]             data_cnt_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  state;
    logic                    grant_data;

    logic                    i_valid;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic                    d_valid;
    logic                    d_is_write;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH/8-1:0] d_wstrb;

    logic                    issue;
    logic                    active;
    logic                    sel_data;
    logic                    i_done;
    logic                    d_done;
    logic                    d_req;

    // Issue/complete decode; the bus is driven straight from the selected slot
    // so it appears in the issue cycle and vanishes asynchronously on reset.
    always_comb begin
        issue         = (state == S_IDLE) && (i_valid || d_valid);
        active        = issue || (state == S_WAIT);
        sel_data      = (state == S_IDLE) ? d_valid : grant_data;
        i_done        = (state == S_WAIT) && mem_ready_i && !grant_data;
        d_done        = (state == S_WAIT) && mem_ready_i && grant_data;
        d_req         = data_read_i || data_write_i;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_wstrb_o   = '0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        if (active) begin
            if (sel_data) begin
                mem_addr_o  = d_addr;
                mem_wdata_o = d_wdata;
                mem_wstrb_o = d_is_write ? d_wstrb : '0;
            end else begin
                mem_addr_o  = i_addr;
            end
        end
        if (issue) begin
            mem_write_o = sel_data && d_is_write;
            mem_read_o  = !(sel_data && d_is_write);
        end
        instr_ready_o = i_done;
        data_ready_o  = d_done;
        instr_rdata_o = i_done ? mem_rdata_i : '0;
        data_rdata_o  = d_done ? mem_rdata_i : '0;
    end

    // Grant FSM: issue from IDLE (data first), wait for the memory handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            grant_data <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (i_valid || d_valid) begin
                    grant_data <= d_valid;
                    state      <= S_WAIT;
                end
                S_WAIT: if (mem_ready_i) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Instruction slot: a new pulse may refill a slot completing this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_valid <= 1'b0;
            i_addr  <= '0;
        end else if (instr_req_i && (!i_valid || i_done)) begin
            i_valid <= 1'b1;
            i_addr  <= instr_addr_i;
        end else if (i_done) begin
            i_valid <= 1'b0;
        end
    end

    // Data slot: on a simultaneous read and write pulse the write is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid    <= 1'b0;
            d_is_write <= 1'b0;
            d_addr     <= '0;
            d_wdata    <= '0;
            d_wstrb    <= '0;
        end else if (d_req && (!d_valid || d_done)) begin
            d_valid    <= 1'b1;
            d_is_write <= data_write_i;
            d_addr     <= data_addr_i;
            d_wdata    <= data_wdata_i;
            d_wstrb    <= data_wstrb_i;
        end else if (d_done) begin
            d_valid    <= 1'b0;
        end
    end

    // Sticky error: dropped duplicate pulses or a read+write collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if ((instr_req_i && i_valid && !i_done) ||
                     (d_req && d_valid && !d_done) ||
                     (data_read_i && data_write_i)) begin
            err_o <= 1'b1;
        end
    end

    // Wrapping completion counters for performance monitoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_o <= '0;
            data_cnt_o  <= '0;
        end else begin
            if (i_done) instr_cnt_o <= instr_cnt_o + 32'd1;
            if (d_done) data_cnt_o  <= data_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a response scoreboard per port.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_rdata_o;
    logic        instr_ready_o;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [3:0]  data_wstrb_i = '0;
    logic        data_read_i = 1'b0;
    logic        data_write_i = 1'b0;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ready_i = 1'b0;
    logic        err_o;
    logic [31:0] instr_cnt_o;
    logic [31:0] data_cnt_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] iq[$];
    logic [31:0] dq[$];

    unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_addr_i(instr_addr_i), .instr_req_i(instr_req_i),
        .instr_rdata_o(instr_rdata_o), .instr_ready_o(instr_ready_o),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_wstrb_i(data_wstrb_i), .data_read_i(data_read_i),
        .data_write_i(data_write_i), .data_rdata_o(data_rdata_o),
        .data_ready_o(data_ready_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .err_o(err_o), .instr_cnt_o(instr_cnt_o), .data_cnt_o(data_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        instr_req_i  = 1'b0;
        data_read_i  = 1'b0;
        data_write_i = 1'b0;
    endtask

    // One-cycle request pulse; returns just after the capturing edge.
    task automatic pulse(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                         input logic [3:0] ds);
        @(posedge clk); #1;
        instr_req_i = ir; instr_addr_i = ia;
        data_read_i = dr; data_write_i = dw;
        data_addr_i = da; data_wdata_i = dwd; data_wstrb_i = ds;
        @(posedge clk); #1;
        clear_reqs();
    endtask

    // Memory model for one transaction: find the issue pulse, check the bus,
    // check it is held, then return mem_ready_i after lat cycles.
    task automatic serve(input string tag, input logic is_wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] rdata, input int unsigned lat,
                         input int unsigned exp_wait);
        int unsigned waited = 0;
        while (!(mem_read_o || mem_write_o) || waited == 0) begin
            @(negedge clk);
            waited++;
            if (waited > 20) break;
        end
        if (waited > 20) begin
            check({tag, "_issue_timeout"}, {31'd0, mem_read_o | mem_write_o}, 32'd1);
            return;
        end
        if (exp_wait != 0) check({tag, "_issue_latency"}, waited, exp_wait);
        check({tag, "_read"}, {31'd0, mem_read_o}, {31'd0, ~is_wr});
        check({tag, "_write"}, {31'd0, mem_write_o}, {31'd0, is_wr});
        check({tag, "_addr"}, mem_addr_o, addr);
        check({tag, "_wstrb"}, {28'd0, mem_wstrb_o}, is_wr ? {28'd0, wstrb} : 32'd0);
        if (is_wr) check({tag, "_wdata"}, mem_wdata_o, wdata);
        @(posedge clk); #1;
        clear_reqs();
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check({tag, "_addr_held"}, mem_addr_o, addr);
            check({tag, "_pulse_once"}, {31'd0, mem_read_o | mem_write_o}, 32'd0);
            if (k + 1 < lat) @(posedge clk);
        end
        @(posedge clk); #1;
        mem_ready_i = 1'b1; mem_rdata_i = rdata;
        @(posedge clk); #1;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
    endtask

    // Response monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_ready_o) begin
                if (iq.size() == 0) check("instr_unexpected_ready", {31'd0, instr_ready_o}, 32'd0);
                else check("instr_rdata", instr_rdata_o, iq.pop_front());
            end else check("instr_rdata_idle", instr_rdata_o, 32'd0);
            if (data_ready_o) begin
                if (dq.size() == 0) check("data_unexpected_ready", {31'd0, data_ready_o}, 32'd0);
                else check("data_rdata", data_rdata_o, dq.pop_front());
            end else check("data_rdata_idle", data_rdata_o, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_mem_read", {31'd0, mem_read_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_cnts", instr_cnt_o | data_cnt_o, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single fetch, latency 3
        iq.push_back(32'h0050_0093);
        pulse(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0);
        serve("fetch", 1'b0, 32'h100, '0, '0, 32'h0050_0093, 3, 1);
        check("fetch_icnt", instr_cnt_o, 32'd1);

        // Store
        dq.push_back(32'h0);
        pulse(1'b0, '0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF);
        serve("store", 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 32'h0, 2, 1);
        check("store_dcnt", data_cnt_o, 32'd1);
        check("store_icnt", instr_cnt_o, 32'd1);

        // Simultaneous fetch and load: data first, fetch right after
        dq.push_back(32'h1111_2222);
        iq.push_back(32'h3333_4444);
        pulse(1'b1, 32'h140, 1'b1, 1'b0, 32'h240, '0, 4'hF);
        serve("sim_load", 1'b0, 32'h240, '0, '0, 32'h1111_2222, 2, 1);
        check("sim_dcnt", data_cnt_o, 32'd2);
        serve("sim_fetch", 1'b0, 32'h140, '0, '0, 32'h3333_4444, 2, 1);
        check("sim_icnt", instr_cnt_o, 32'd2);
        check("err_clean", {31'd0, err_o}, 32'd0);

        // Duplicate fetch pulse while pending is dropped
        iq.push_back(32'hAAAA_5555);
        pulse(1'b1, 32'h300, 1'b0, 1'b0, '0, '0, '0);
        instr_req_i = 1'b1; instr_addr_i = 32'h400;
        serve("dup", 1'b0, 32'h300, '0, '0, 32'hAAAA_5555, 2, 1);
        check("dup_err", {31'd0, err_o}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("dup_no_reissue", {31'd0, mem_read_o}, 32'd0);
        end
        check("dup_icnt", instr_cnt_o, 32'd3);
        check("dup_err_sticky", {31'd0, err_o}, 32'd1);

        // Reset two cycles after mem_read_o aborts the fetch
        pulse(1'b1, 32'h500, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("rstw_issue", {31'd0, mem_read_o}, 32'd1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rstw_addr", mem_addr_o, 32'd0);
        check("rstw_read", {31'd0, mem_read_o}, 32'd0);
        check("rstw_err", {31'd0, err_o}, 32'd0);
        check("rstw_cnt", instr_cnt_o | data_cnt_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready_i = 1'b1; mem_rdata_i = 32'h0000_0BAD;
        @(negedge clk);
        check("rstw_no_ready", {31'd0, instr_ready_o | data_ready_o}, 32'd0);
        check("rstw_no_issue", {31'd0, mem_read_o | mem_write_o}, 32'd0);
        @(posedge clk); #1;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
        @(negedge clk);
        check("rstw_icnt", instr_cnt_o, 32'd0);

        // Read and write pulsed together: write wins, error flagged
        dq.push_back(32'h0);
        pulse(1'b0, '0, 1'b1, 1'b1, 32'h600, 32'hCAFE_F00D, 4'h3);
        serve("rw", 1'b1, 32'h600, 32'hCAFE_F00D, 4'h3, 32'h0, 2, 1);
        check("rw_err", {31'd0, err_o}, 32'd1);
        check("rw_dcnt", data_cnt_o, 32'd1);

        @(negedge clk);
        check("iq_drained", iq.size(), 32'd0);
        check("dq_drained", dq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
